// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one magic_memory-style port between the instruction (A)
// and data (B) requesters; one registered downstream transaction at a time.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int B_PRIORITY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_read,
    input  logic [ADDR_WIDTH-1:0] a_address,
    output logic                  a_resp,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_read,
    input  logic                  b_write,
    input  logic [MASK_WIDTH-1:0] b_wmask,
    input  logic [ADDR_WIDTH-1:0] b_address,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_resp,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MASK_WIDTH-1:0] mem_wmask,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_resp,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            dbg_state
);

    // Handshake: a requester holds read/write and its operands until it sees its
    // single-cycle resp; downstream, mem_* hold steady until the one-cycle mem_resp.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_grant_b;
    logic   a_req, b_req, b_wins_tie;

    assign a_req      = a_read;
    assign b_req      = b_read | b_write;
    assign b_wins_tie = (B_PRIORITY != 0) ? 1'b1 : !last_grant_b;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (b_req && (!a_req || b_wins_tie)) state_nxt = SERVE_B;
                else if (a_req)                      state_nxt = SERVE_A;
            end
            SERVE_A, SERVE_B: begin
                if (mem_resp) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Downstream request is captured on the grant edge; a write wins over a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_wmask    <= '0;
            mem_address  <= '0;
            mem_wdata    <= '0;
            last_grant_b <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_nxt == SERVE_B) begin
                        mem_read    <= b_read & ~b_write;
                        mem_write   <= b_write;
                        mem_wmask   <= b_wmask;
                        mem_address <= b_address;
                        mem_wdata   <= b_wdata;
                    end else if (state_nxt == SERVE_A) begin
                        mem_read    <= 1'b1;
                        mem_write   <= 1'b0;
                        mem_wmask   <= '0;
                        mem_address <= a_address;
                        mem_wdata   <= '0;
                    end
                end
                SERVE_A: begin
                    if (mem_resp) begin
                        mem_read     <= 1'b0;
                        mem_write    <= 1'b0;
                        last_grant_b <= 1'b0;
                    end
                end
                SERVE_B: begin
                    if (mem_resp) begin
                        mem_read     <= 1'b0;
                        mem_write    <= 1'b0;
                        last_grant_b <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion is routed combinationally to the granted port only.
    always_comb begin
        a_resp    = 1'b0;
        b_resp    = 1'b0;
        a_rdata   = '0;
        b_rdata   = '0;
        dbg_state = state;
        if (state == SERVE_A && mem_resp) begin
            a_resp  = 1'b1;
            a_rdata = mem_rdata;
        end
        if (state == SERVE_B && mem_resp) begin
            b_resp  = 1'b1;
            b_rdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transaction table, corner sequences,
// a round-robin instance, and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam int         PRI     = 1;

    logic        clk, rst;
    logic        a_read, a_resp, b_read, b_write, b_resp;
    logic [31:0] a_address, a_rdata, b_address, b_wdata, b_rdata;
    logic [3:0]  b_wmask, mem_wmask;
    logic        mem_read, mem_write, mem_resp;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic [1:0]  dbg_state;

    logic        rr_a_read, rr_a_resp, rr_b_read, rr_b_write, rr_b_resp;
    logic [31:0] rr_a_address, rr_a_rdata, rr_b_address, rr_b_wdata, rr_b_rdata;
    logic [3:0]  rr_b_wmask, rr_mem_wmask;
    logic        rr_mem_read, rr_mem_write, rr_mem_resp;
    logic [31:0] rr_mem_address, rr_mem_wdata, rr_mem_rdata;
    logic [1:0]  rr_dbg_state;

    mem_port_arbiter #(.B_PRIORITY(PRI)) dut (
        .clk(clk), .rst(rst),
        .a_read(a_read), .a_address(a_address), .a_resp(a_resp), .a_rdata(a_rdata),
        .b_read(b_read), .b_write(b_write), .b_wmask(b_wmask), .b_address(b_address),
        .b_wdata(b_wdata), .b_resp(b_resp), .b_rdata(b_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_resp(mem_resp),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    mem_port_arbiter #(.B_PRIORITY(0)) dut_rr (
        .clk(clk), .rst(rst),
        .a_read(rr_a_read), .a_address(rr_a_address), .a_resp(rr_a_resp), .a_rdata(rr_a_rdata),
        .b_read(rr_b_read), .b_write(rr_b_write), .b_wmask(rr_b_wmask), .b_address(rr_b_address),
        .b_wdata(rr_b_wdata), .b_resp(rr_b_resp), .b_rdata(rr_b_rdata),
        .mem_read(rr_mem_read), .mem_write(rr_mem_write), .mem_wmask(rr_mem_wmask),
        .mem_address(rr_mem_address), .mem_wdata(rr_mem_wdata), .mem_resp(rr_mem_resp),
        .mem_rdata(rr_mem_rdata), .dbg_state(rr_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_model[logic [31:0]];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        return mem_model.exists(addr) ? mem_model[addr] : 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        logic [31:0] w;
        w = model_read(addr);
        for (int i = 0; i < 4; i++)
            if (mask[i]) w[8*i +: 8] = data[8*i +: 8];
        mem_model[addr] = w;
    endtask

    // Protocol invariants watched every cycle on both instances.
    always @(negedge clk) begin
        check1("mem_rd_wr_exclusive", mem_read & mem_write, 1'b0);
        check1("rr_mem_rd_wr_exclusive", rr_mem_read & rr_mem_write, 1'b0);
        check1("b_read_write_illegal", b_read & b_write, 1'b0);
    end

    typedef struct {
        logic        is_b;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          lat;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic run_txn(input vec_t v);
        if (!v.is_b) begin
            a_read = 1'b1; a_address = v.addr;
        end else begin
            b_read = !v.wr; b_write = v.wr; b_address = v.addr;
            b_wdata = v.wdata; b_wmask = v.wmask;
        end
        tick();
        check1("txn_mem_read", mem_read, !(v.is_b && v.wr));
        check1("txn_mem_write", mem_write, v.is_b && v.wr);
        check32("txn_mem_address", mem_address, v.addr);
        check32("txn_mem_wmask", {28'd0, mem_wmask}, v.is_b ? {28'd0, v.wmask} : 32'd0);
        check32("txn_mem_wdata", mem_wdata, v.is_b ? v.wdata : 32'd0);
        check1("txn_not_idle", dbg_state == ST_IDLE, 1'b0);
        for (int i = 0; i < v.lat; i++) begin
            check1("txn_wait_a_resp", a_resp, 1'b0);
            check1("txn_wait_b_resp", b_resp, 1'b0);
            tick();
            check32("txn_hold_address", mem_address, v.addr);
        end
        mem_resp  = 1'b1;
        mem_rdata = v.wr ? 32'h0 : model_read(v.addr);
        #1;
        check1("txn_a_resp", a_resp, !v.is_b);
        check1("txn_b_resp", b_resp, v.is_b);
        check32("txn_a_rdata", a_rdata, v.is_b ? 32'd0 : v.exp_rdata);
        check32("txn_b_rdata", b_rdata, v.is_b ? v.exp_rdata : 32'd0);
        if (v.is_b && v.wr) model_write(v.addr, v.wdata, v.wmask);
        tick();
        mem_resp = 1'b0; mem_rdata = 32'h0;
        a_read = 1'b0; b_read = 1'b0; b_write = 1'b0;
        check1("txn_done_read", mem_read, 1'b0);
        check1("txn_done_write", mem_write, 1'b0);
        check32("txn_done_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    endtask

    logic        a_pend, b_pend, b_is_wr, busy, cur_b, last_b;
    logic        prev_a, prev_b, prev_idle, exp_op, w_b, responding, was_busy;
    logic        done_a, done_b;
    logic        s_rd, s_wr;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wmask;
    int          cnt;

    initial begin
        rst = 1'b1;
        a_read = 0; a_address = 0; b_read = 0; b_write = 0; b_wmask = 0; b_address = 0; b_wdata = 0;
        mem_resp = 0; mem_rdata = 0;
        rr_a_read = 0; rr_a_address = 0; rr_b_read = 0; rr_b_write = 0; rr_b_wmask = 0;
        rr_b_address = 0; rr_b_wdata = 0; rr_mem_resp = 0; rr_mem_rdata = 0;

        vecs[0] = '{1'b0, 1'b0, 32'h60,  32'h0,        4'h0, 3, 32'h00000063};
        vecs[1] = '{1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3, 1, 32'h00000000};
        vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0,        4'h0, 0, 32'h0000BEEF};
        vecs[3] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 2, 32'h0000BEEF};
        vecs[4] = '{1'b1, 1'b1, 32'h100, 32'h12345678, 4'hC, 0, 32'h00000000};
        vecs[5] = '{1'b1, 1'b0, 32'h100, 32'h0,        4'h0, 1, 32'h1234BEEF};
        mem_model[32'h60] = 32'h63;

        repeat (3) tick();
        check1("rst_mem_read", mem_read, 1'b0);
        check1("rst_mem_write", mem_write, 1'b0);
        check32("rst_mem_address", mem_address, 32'h0);
        check32("rst_mem_wdata", mem_wdata, 32'h0);
        check32("rst_mem_wmask", {28'd0, mem_wmask}, 32'h0);
        check1("rst_a_resp", a_resp, 1'b0);
        check1("rst_b_resp", b_resp, 1'b0);
        check32("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Simultaneous requests: B first, one bubble, then A.
        a_read = 1; a_address = 32'h10; b_read = 1; b_address = 32'h20; b_wmask = 0; b_wdata = 0;
        tick();
        check32("tie_first_addr", mem_address, 32'h20);
        check1("tie_first_read", mem_read, 1'b1);
        mem_resp = 1; mem_rdata = 32'h2222;
        #1;
        check1("tie_b_resp", b_resp, 1'b1);
        check1("tie_a_quiet", a_resp, 1'b0);
        check32("tie_b_rdata", b_rdata, 32'h2222);
        check32("tie_a_rdata_zero", a_rdata, 32'h0);
        tick();
        mem_resp = 0; b_read = 0;
        check1("tie_bubble_read", mem_read, 1'b0);
        check32("tie_bubble_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        tick();
        check32("tie_second_addr", mem_address, 32'h10);
        check1("tie_second_read", mem_read, 1'b1);
        check32("tie_second_wdata", mem_wdata, 32'h0);
        mem_resp = 1; mem_rdata = 32'h1111;
        #1;
        check1("tie_a_resp", a_resp, 1'b1);
        check32("tie_a_rdata", a_rdata, 32'h1111);
        check1("tie_b_quiet", b_resp, 1'b0);
        tick();
        a_read = 0; mem_resp = 0;
        tick();

        // Spurious mem_resp in IDLE.
        mem_resp = 1; mem_rdata = 32'h5555;
        #1;
        check1("spur_a_resp", a_resp, 1'b0);
        check1("spur_b_resp", b_resp, 1'b0);
        check32("spur_a_rdata", a_rdata, 32'h0);
        tick();
        mem_resp = 0;
        check32("spur_addr_kept", mem_address, 32'h10);
        check1("spur_read_low", mem_read, 1'b0);
        check32("spur_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        // Reset while serving A, then a late mem_resp.
        a_read = 1; a_address = 32'h200;
        tick();
        check1("rstmid_granted", mem_read, 1'b1);
        tick();
        rst = 1; a_read = 0;
        tick();
        check1("rstmid_read_drop", mem_read, 1'b0);
        check32("rstmid_addr_zero", mem_address, 32'h0);
        check32("rstmid_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        rst = 0; mem_resp = 1; mem_rdata = 32'hBAD;
        #1;
        check1("rstmid_no_a_resp", a_resp, 1'b0);
        check1("rstmid_no_b_resp", b_resp, 1'b0);
        tick();
        mem_resp = 0;
        check1("rstmid_still_read_low", mem_read, 1'b0);
        check32("rstmid_still_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        // Round-robin instance: both ports request continuously.
        for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 32'hB0 : 32'hA0);
        rr_a_read = 1; rr_a_address = 32'hA0; rr_b_read = 1; rr_b_address = 32'hB0;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] exp_addr;
            exp_addr = exp_q.pop_front();
            tick();
            check32("rr_grant_addr", rr_mem_address, exp_addr);
            check1("rr_grant_read", rr_mem_read, 1'b1);
            rr_mem_resp = 1; rr_mem_rdata = 32'h1000 + i;
            #1;
            check1("rr_b_resp", rr_b_resp, exp_addr == 32'hB0);
            check1("rr_a_resp", rr_a_resp, exp_addr == 32'hA0);
            check32("rr_rdata", (exp_addr == 32'hB0) ? rr_b_rdata : rr_a_rdata, 32'h1000 + i);
            tick();
            rr_mem_resp = 0;
            check1("rr_bubble", rr_mem_read, 1'b0);
        end
        rr_a_read = 0; rr_b_read = 0;

        // Randomized traffic against a transaction-level model.
        rst = 1;
        tick();
        rst = 0;
        a_pend = 0; b_pend = 0; b_is_wr = 0; busy = 0; cur_b = 0; last_b = 0;
        prev_a = 0; prev_b = 0; prev_idle = 1; cnt = 0;
        s_rd = 0; s_wr = 0; s_addr = 0; s_wdata = 0; s_wmask = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            was_busy = busy;
            exp_op = 1'b0;
            done_a = 1'b0; done_b = 1'b0;
            if (!busy) begin
                exp_op = prev_idle && (prev_a || prev_b);
                check1("rnd_grant_present", mem_read | mem_write, exp_op);
                if (exp_op) begin
                    w_b = prev_b && (!prev_a || PRI != 0 || !last_b);
                    s_addr  = w_b ? b_address : a_address;
                    s_rd    = w_b ? !b_is_wr : 1'b1;
                    s_wr    = w_b ? b_is_wr : 1'b0;
                    s_wmask = w_b ? b_wmask : 4'h0;
                    s_wdata = w_b ? b_wdata : 32'h0;
                    check32("rnd_grant_addr", mem_address, s_addr);
                    check1("rnd_grant_read", mem_read, s_rd);
                    check1("rnd_grant_write", mem_write, s_wr);
                    check32("rnd_grant_wmask", {28'd0, mem_wmask}, {28'd0, s_wmask});
                    check32("rnd_grant_wdata", mem_wdata, s_wdata);
                    busy = 1; cur_b = w_b; cnt = $urandom_range(0, 3);
                end
            end else begin
                check32("rnd_hold_addr", mem_address, s_addr);
                check1("rnd_hold_read", mem_read, s_rd);
                check1("rnd_hold_write", mem_write, s_wr);
            end
            responding = busy && (cnt == 0);
            if (busy && cnt != 0) cnt--;
            if (responding) begin
                mem_resp  = 1'b1;
                mem_rdata = s_wr ? $urandom : model_read(s_addr);
            end else begin
                mem_resp  = !busy && ($urandom_range(0, 7) == 0);
                mem_rdata = $urandom;
            end
            #1;
            check1("rnd_a_resp", a_resp, responding && !cur_b);
            check1("rnd_b_resp", b_resp, responding && cur_b);
            check32("rnd_a_rdata", a_rdata, (responding && !cur_b) ? mem_rdata : 32'h0);
            check32("rnd_b_rdata", b_rdata, (responding && cur_b) ? mem_rdata : 32'h0);
            if (responding) begin
                if (cur_b && s_wr) model_write(s_addr, s_wdata, s_wmask);
                if (cur_b) begin
                    b_pend = 0; b_read = 0; b_write = 0; done_b = 1;
                end else begin
                    a_pend = 0; a_read = 0; done_a = 1;
                end
                last_b = cur_b;
                busy = 0;
            end
            if (!a_pend && !done_a && $urandom_range(0, 2) == 0) begin
                a_pend = 1; a_read = 1;
                a_address = 32'($urandom_range(0, 15)) << 2;
            end
            if (!b_pend && !done_b && $urandom_range(0, 2) == 0) begin
                b_pend = 1; b_is_wr = 1'($urandom_range(0, 1));
                b_read = !b_is_wr; b_write = b_is_wr;
                b_address = 32'($urandom_range(0, 15)) << 2;
                b_wdata = $urandom; b_wmask = 4'($urandom);
            end
            prev_a = a_read;
            prev_b = b_read | b_write;
            prev_idle = !was_busy && !exp_op;
        end
        a_read = 0; b_read = 0; b_write = 0; mem_resp = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port (read/write/wmask/address/wdata/resp/rdata, magic_memory-style handshake) between the CPU instruction port (A, read-only) and data port (B, read/write).
- Sits between mp3_cpu and the memory model / cache hierarchy.
- Serialises one transaction at a time, registers the downstream request, and routes resp/rdata back to the granted requester only.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- MASK_WIDTH, DATA_WIDTH/8, byte-enable width
- B_PRIORITY, 1, 1 = fixed priority to B on a tie; 0 = round-robin on a tie

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- a_read  in  1  instruction read request, held until a_resp
- a_address  in  ADDR_WIDTH  instruction address
- a_resp  out  1  instruction transaction done
- a_rdata  out  DATA_WIDTH  instruction read data
- b_read  in  1  data read request, held until b_resp
- b_write  in  1  data write request, held until b_resp
- b_wmask  in  MASK_WIDTH  byte enables for write
- b_address  in  ADDR_WIDTH  data address
- b_wdata  in  DATA_WIDTH  write data
- b_resp  out  1  data transaction done
- b_rdata  out  DATA_WIDTH  data read data
- mem_read  out  1  downstream read
- mem_write  out  1  downstream write
- mem_wmask  out  MASK_WIDTH  downstream byte enables
- mem_address  out  ADDR_WIDTH  downstream address
- mem_wdata  out  DATA_WIDTH  downstream write data
- mem_resp  in  1  downstream done, single-cycle pulse
- mem_rdata  in  DATA_WIDTH  downstream read data, valid with mem_resp

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- FSM states: IDLE, SERVE_A, SERVE_B. Reset state is IDLE.
- Reset values: all mem_* registers 0; a_resp = b_resp = 0; a_rdata = b_rdata = 0 when not responding. The round-robin last_grant register resets to A, so B wins the first tie.
- IDLE, choosing a grant:
  - Only A requests -> SERVE_A.
  - Only B requests (b_read|b_write) -> SERVE_B.
  - Both request: B_PRIORITY=1 -> SERVE_B; B_PRIORITY=0 -> the port not equal to last_grant.
- Grant edge: mem_address, mem_wmask, mem_wdata and the read/write bits are latched from the winner.
  - A grant: mem_read=1, mem_write=0, mem_wmask=0.
- Latency:
  - A request first sampled in IDLE at edge N drives mem_* from cycle N+1.
  - Minimum round trip is 2 cycles: request cycle plus one cycle with mem_resp.
- SERVE_x:
  - mem_* stay constant until mem_resp.
  - On the mem_resp cycle: x_resp=1 and x_rdata=mem_rdata, combinational in the same cycle.
  - The other port's resp stays 0 and its rdata stays 0.
  - On the next edge: clear mem_read/mem_write, return to IDLE, set last_grant=x.
- Back-to-back: a requester that sees resp may present a new request in the following cycle. That IDLE cycle re-arbitrates, so there is one bubble cycle between transactions.
- A requester that is not granted waits indefinitely; its inputs are ignored until grant.
- With B_PRIORITY=0, round-robin guarantees no starvation.
- b_read & b_write together is illegal (bench asserts on it). The RTL forwards the write only: mem_write=1, mem_read=0.
- mem_read and mem_write are never both 1.
- mem_resp while in IDLE (stale or spurious) is ignored: no resp to either port, no state change.
- rst mid-transaction:
  - Next cycle: IDLE, mem_* = 0, no resp issued.
  - A late mem_resp after reset is ignored (IDLE rule above).
- Requests deasserted before resp are a protocol violation. The in-flight transaction completes anyway.

Test Plan:
- Single A read @0x00000060, memory returns 0x00000063 after 3 cycles -> mem_read=1 with addr 0x60 one cycle after a_read. a_resp=1 with a_rdata=0x63 in the mem_resp cycle; b_resp stays 0.
- Single B write @0x100, wdata 0xDEADBEEF, wmask 4'b0011 -> mem_write=1, mem_wmask=0011, mem_wdata=0xDEADBEEF. b_resp pulses one cycle; readback via B read returns 0x0000BEEF in the low half.
- Simultaneous A read @0x10 and B read @0x20, B_PRIORITY=1 -> B served first. A is granted in the IDLE cycle after b_resp, so mem_address sequence is 0x20 then 0x10.
- B_PRIORITY=0, both ports requesting continuously for 6 transactions -> grants alternate B,A,B,A,B,A, with no port served twice in a row.
- Assert rst for one cycle while in SERVE_A before mem_resp, then pulse mem_resp -> mem_read drops the cycle after rst; no a_resp is issued; FSM is in IDLE.
- Spurious mem_resp in IDLE with no requests -> a_resp=b_resp=0 and the mem_* outputs are unchanged.
